// File: rtl/pipe_pkg.sv
// Shared widths, PC step and the bubble encoding used by every pipeline register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (bubble insert) and freeze (hold).
// Latency: 1 cycle from pc_in/instr_in to outputs.
// Backpressure: freeze holds contents; flush wins over freeze.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [INSTR_W-1:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid
);

    if_id_t stage_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '{pc: '0, instr: FLUSH_INSTR, valid: 1'b0};
        end else if (flush) begin
            // The held instruction is on the wrong path, so flush beats freeze.
            stage_q <= '{pc: '0, instr: FLUSH_INSTR, valid: 1'b0};
        end else if (!freeze) begin
            stage_q <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
        end
    end

    assign pc_out    = stage_q.pc;
    assign instr_out = stage_q.instr;
    assign valid     = stage_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select and the IF/ID register.
// Latency: imem_addr is combinational from PC; fetched word reaches decode 1 cycle later.
// Backpressure: freeze holds PC and IF/ID; a taken branch redirects and flushes regardless.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  PC_out,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;

    assign pc_plus4  = pc + PC_STEP;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= word_align(branch_addr);
        end else if (!freeze) begin
            pc <= pc_plus4;
        end
    end

    if_id_reg #(
        .FLUSH_INSTR (FLUSH_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (branch_taken),
        .pc_in     (pc_plus4),
        .instr_in  (imem_data),
        .pc_out    (PC_out),
        .instr_out (instruction),
        .valid     (valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, run, freeze, branch, branch-over-freeze, wrap, async reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] PC_out;
    logic [31:0] instruction;
    logic        valid;

    int checks;
    int errors;

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .PC_out       (PC_out),
        .instruction  (instruction),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: fixed word at 0, address-tagged words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE3A0_1005 : (32'hE000_0000 ^ a);
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        step(); step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", instruction, 32'h0); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h want %h", PC_out, 32'h0); end
        rst = 1'b1;
        step();
        checks++; if (instruction !== 32'hE3A0_1005) begin errors++; $display("FAIL run_instr0 got %h want %h", instruction, 32'hE3A0_1005); end
        checks++; if (PC_out !== 32'h4) begin errors++; $display("FAIL run_pc_out0 got %h want %h", PC_out, 32'h4); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL run_valid0 got %b want 1", valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL run_addr4 got %h want %h", imem_addr, 32'h4); end
        step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL run_addr8 got %h want %h", imem_addr, 32'h8); end
        checks++; if (instruction !== 32'hE000_0004) begin errors++; $display("FAIL run_instr1 got %h want %h", instruction, 32'hE000_0004); end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL freeze_addr[%0d] got %h want %h", i, imem_addr, 32'h8); end
            checks++; if (PC_out !== 32'h8) begin errors++; $display("FAIL freeze_pc_out[%0d] got %h want %h", i, PC_out, 32'h8); end
            checks++; if (instruction !== 32'hE000_0004) begin errors++; $display("FAIL freeze_instr[%0d] got %h want %h", i, instruction, 32'hE000_0004); end
        end
        freeze = 1'b0;
        step();
        checks++; if (PC_out !== 32'hC) begin errors++; $display("FAIL unfreeze_pc_out got %h want %h", PC_out, 32'hC); end
        checks++; if (instruction !== 32'hE000_0008) begin errors++; $display("FAIL unfreeze_instr got %h want %h", instruction, 32'hE000_0008); end
        step();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL run_addr10 got %h want %h", imem_addr, 32'h10); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_addr = 32'h0000_0040;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL branch_addr got %h want %h", imem_addr, 32'h40); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL branch_valid got %b want 0", valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL branch_flush_instr got %h want %h", instruction, 32'h0); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL branch_flush_pc got %h want %h", PC_out, 32'h0); end
        step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL branch_next_valid got %b want 1", valid); end
        checks++; if (PC_out !== 32'h44) begin errors++; $display("FAIL branch_next_pc_out got %h want %h", PC_out, 32'h44); end
        checks++; if (instruction !== 32'hE000_0040) begin errors++; $display("FAIL branch_next_instr got %h want %h", instruction, 32'hE000_0040); end
    endtask

    task automatic test_branch_freeze();
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bfreeze_addr got %h want %h", imem_addr, 32'h100); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bfreeze_valid got %b want 0", valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL bfreeze_instr got %h want %h", instruction, 32'h0); end
        step();
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bfreeze_hold_addr got %h want %h", imem_addr, 32'h100); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bfreeze_hold_valid got %b want 0", valid); end
        freeze = 1'b0;
        step();
        checks++; if (PC_out !== 32'h104) begin errors++; $display("FAIL bfreeze_resume_pc got %h want %h", PC_out, 32'h104); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bfreeze_resume_valid got %b want 1", valid); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        step();
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL wrap_pc_out got %h want %h", PC_out, 32'h0); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h want %h", imem_addr, 32'h0); end
        checks++; if (instruction !== 32'h1FFF_FFFC) begin errors++; $display("FAIL wrap_instr got %h want %h", instruction, 32'h1FFF_FFFC); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", valid); end
    endtask

    task automatic test_async_reset();
        branch_taken = 1'b1; branch_addr = 32'h0000_0020;
        step();
        branch_taken = 1'b0;
        step();
        checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL pre_areset_addr got %h want %h", imem_addr, 32'h24); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pre_areset_valid got %b want 1", valid); end
        #2;
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0200;
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL areset_addr got %h want %h", imem_addr, 32'h0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", valid); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL areset_pc_out got %h want %h", PC_out, 32'h0); end
        step();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL areset_hold_addr got %h want %h", imem_addr, 32'h0); end
        freeze = 1'b0; branch_taken = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (PC_out !== 32'h4) begin errors++; $display("FAIL areset_resume_pc got %h want %h", PC_out, 32'h4); end
        checks++; if (instruction !== 32'hE3A0_1005) begin errors++; $display("FAIL areset_resume_instr got %h want %h", instruction, 32'hE3A0_1005); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_freeze();
        test_branch();
        test_branch_freeze();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
